// File: rtl/pipelined_doubling_adder.sv
// Pipelined Kogge-Stone adder/subtractor behind a valid/ready elastic pipeline.
// Stage 0 registers generate/propagate; each later stage resolves LVL_PER prefix levels.
module pipelined_doubling_adder #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned LVL_PER = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum,
    output logic             ovf
);
    localparam int unsigned LOG2W = $clog2(WIDTH);
    localparam int unsigned NPRE  = (LOG2W + LVL_PER - 1) / LVL_PER;
    localparam int unsigned NREG  = 1 + NPRE;
    localparam int unsigned NMID  = NREG - 1;

    // Applies prefix levels lo..hi-1; bits below the level distance pass through.
    function automatic logic [2*WIDTH-1:0] prefix_levels(
        input logic [WIDTH-1:0] g_in,
        input logic [WIDTH-1:0] p_in,
        input int unsigned      lo,
        input int unsigned      hi
    );
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] low_mask;
        int unsigned      d;
        g = g_in;
        p = p_in;
        for (int unsigned k = 0; k < LOG2W; k++) begin
            if (k >= lo && k < hi) begin
                d        = 32'd1 << k;
                low_mask = (WIDTH'(1) << d) - WIDTH'(1);
                g        = g | (p & (g << d));
                p        = (p & (p << d)) | (p & low_mask);
            end
        end
        return {p, g};
    endfunction

    logic [WIDTH-1:0]   g_q  [NMID];
    logic [WIDTH-1:0]   p_q  [NMID];
    logic [WIDTH-1:0]   pr_q [NMID];
    logic               c0_q [NMID];
    logic               am_q [NMID];
    logic               bm_q [NMID];
    logic [2*WIDTH-1:0] pg_c [NMID];
    logic [NREG-1:0]    v;
    logic [NREG-1:0]    en;
    logic [WIDTH-1:0]   bb_c;
    logic [WIDTH-1:0]   g0_c;
    logic [WIDTH-1:0]   p0_c;
    logic               c0_c;
    logic [WIDTH-1:0]   gf_c;
    logic [WIDTH-1:0]   s_c;

    // A stage may load when it or any stage downstream of it is empty, or the sink accepts.
    always_comb begin
        en = '0;
        for (int unsigned j = 0; j < NREG; j++) begin
            en[j] = out_ready || ((~v >> j) != '0);
        end
    end

    assign in_ready  = en[0];
    assign out_valid = v[NREG-1];

    always_comb begin
        bb_c    = op_sub ? ~b : b;
        c0_c    = op_sub ? ~cin : cin;
        p0_c    = a ^ bb_c;
        g0_c    = a & bb_c;
        g0_c[0] = g0_c[0] | (p0_c[0] & c0_c);
    end

    always_comb begin
        for (int unsigned m = 0; m < NMID; m++) begin
            pg_c[m] = prefix_levels(g_q[m], p_q[m], m * LVL_PER, (m + 1) * LVL_PER);
        end
        gf_c = pg_c[NMID-1][WIDTH-1:0];
        s_c  = pr_q[NMID-1] ^ {gf_c[WIDTH-2:0], c0_q[NMID-1]};
    end

    // Valid bits and the result register are cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            v   <= '0;
            sum <= '0;
            ovf <= 1'b0;
        end else begin
            if (en[0]) v[0] <= in_valid;
            for (int unsigned j = 1; j < NREG; j++) begin
                if (en[j]) v[j] <= v[j-1];
            end
            if (en[NREG-1] && v[NREG-2]) begin
                sum <= {gf_c[WIDTH-1], s_c};
                ovf <= (am_q[NMID-1] == bm_q[NMID-1]) && (s_c[WIDTH-1] != am_q[NMID-1]);
            end
        end
    end

    // Payload registers only move when a valid beat enters them.
    always_ff @(posedge clk) begin
        if (en[0] && in_valid) begin
            g_q[0]  <= g0_c;
            p_q[0]  <= p0_c;
            pr_q[0] <= p0_c;
            c0_q[0] <= c0_c;
            am_q[0] <= a[WIDTH-1];
            bm_q[0] <= bb_c[WIDTH-1];
        end
        for (int unsigned m = 1; m < NMID; m++) begin
            if (en[m] && v[m-1]) begin
                g_q[m]  <= pg_c[m-1][WIDTH-1:0];
                p_q[m]  <= pg_c[m-1][2*WIDTH-1:WIDTH];
                pr_q[m] <= pr_q[m-1];
                c0_q[m] <= c0_q[m-1];
                am_q[m] <= am_q[m-1];
                bm_q[m] <= bm_q[m-1];
            end
        end
    end
endmodule

// File: tb/tb_pipelined_doubling_adder.sv
// Scoreboard bench: directed and backpressure/reset tests on a 16-bit, one-level-per-stage
// instance, plus randomized sweeps over several WIDTH/LVL_PER configurations.
`timescale 1ns/1ps
module tb_pipelined_doubling_adder;
    localparam int unsigned NREG   = 5;
    localparam int unsigned NCFG   = 6;
    localparam int unsigned CFG_W [NCFG] = '{16, 16, 32, 32, 64, 64};
    localparam int unsigned CFG_L [NCFG] = '{2, 4, 2, 5, 2, 6};
    localparam int unsigned NBEATS = 1000;

    localparam logic [15:0] D_A   [8] = '{16'd0, 16'd5560, 16'd61560, 16'hFFFF, 16'h7FFF, 16'd5, 16'h8000, 16'd9};
    localparam logic [15:0] D_B   [8] = '{16'd0, 16'd8101, 16'd60101, 16'h0000, 16'h0001, 16'd7, 16'h0001, 16'd3};
    localparam logic        D_CI  [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam logic        D_SUB [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    localparam logic [16:0] D_SUM [8] = '{17'h00000, 17'd13661, 17'h1DB3D, 17'h10000,
                                          17'h08000, 17'h0FFFE, 17'h17FFF, 17'h10005};
    localparam logic        D_OVF [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    typedef struct packed {
        logic [16:0] s;
        logic        o;
        logic [31:0] c;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Arithmetic reference: {ovf, carry/no-borrow, result} for a w-bit add or subtract.
    function automatic logic [65:0] ref_model(input int unsigned w, input logic [63:0] x,
                                              input logic [63:0] y, input logic ci, input logic sub);
        logic [63:0]        mask;
        logic [65:0]        t;
        logic               cout;
        logic signed [67:0] sx, sy, r, lim;
        logic               o;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        if (!sub) begin
            t    = 66'(x) + 66'(y) + 66'(ci);
            cout = t[w];
        end else begin
            t    = 66'(x) - 66'(y) - 66'(ci);
            cout = (66'(x) >= 66'(y) + 66'(ci));
        end
        sx  = $signed(68'(x)) - (x[w-1] ? (68'sd1 <<< w) : 68'sd0);
        sy  = $signed(68'(y)) - (y[w-1] ? (68'sd1 <<< w) : 68'sd0);
        r   = sub ? (sx - sy - $signed(68'(ci))) : (sx + sy + $signed(68'(ci)));
        lim = 68'sd1 <<< (w - 1);
        o   = (r >= lim) || (r < -lim);
        return {o, cout, t[63:0] & mask};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- main 16-bit instance ----------------
    logic        rst, in_valid, in_ready, cin, op_sub, out_valid, out_ready, ovf;
    logic [15:0] a, b;
    logic [16:0] sum;
    logic        chk_lat;
    exp_t        exp_q [$];
    int          n_out = 0;

    pipelined_doubling_adder #(.WIDTH(16), .LVL_PER(1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .cin(cin), .op_sub(op_sub), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .ovf(ovf)
    );

    logic        prev_stall = 1'b0;
    logic [16:0] prev_sum;
    logic        prev_ovf;
    exp_t        e;

    always @(negedge clk) begin
        #2;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (out_valid !== 1'b1 || sum !== prev_sum || ovf !== prev_ovf) begin
                    failures++;
                    $display("FAIL hold: out_valid=%0b sum=%h ovf=%0b held sum=%h ovf=%0b",
                             out_valid, sum, ovf, prev_sum, prev_ovf);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                n_out++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_out: sum=%h with no beat outstanding", sum);
                end else begin
                    e = exp_q.pop_front();
                    if (sum !== e.s || ovf !== e.o) begin
                        failures++;
                        $display("FAIL result: sum=%h ovf=%0b expected sum=%h ovf=%0b", sum, ovf, e.s, e.o);
                    end else if (chk_lat && (cyc - int'(e.c)) != NREG) begin
                        failures++;
                        $display("FAIL latency: got %0d cycles expected %0d", cyc - int'(e.c), NREG);
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_sum   = sum;
            prev_ovf   = ovf;
        end
    end

    task automatic issue(input logic [15:0] x, input logic [15:0] y, input logic ci,
                         input logic sub, input logic [16:0] es, input logic eo);
        int waited = 0;
        @(negedge clk);
        in_valid = 1'b1; a = x; b = y; cin = ci; op_sub = sub;
        #1;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout: in_ready=%0b expected 1", in_ready);
        end else begin
            exp_q.push_back(exp_t'{s: es, o: eo, c: 32'(cyc)});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic issue_rand();
        logic [15:0] x, y;
        logic        ci, sub;
        logic [65:0] r;
        x = 16'($urandom); y = 16'($urandom); ci = 1'($urandom); sub = 1'($urandom);
        r = ref_model(16, 64'(x), 64'(y), ci, sub);
        issue(x, y, ci, sub, {r[64], r[15:0]}, r[65]);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- randomized configuration sweep ----------------
    logic [NCFG-1:0] sweep_done;

    for (genvar gi = 0; gi < NCFG; gi++) begin : g_sweep
        localparam int unsigned SW = CFG_W[gi];
        localparam int unsigned SL = CFG_L[gi];
        logic          s_rst, s_iv, s_ir, s_cin, s_sub, s_ov, s_or, s_ovf;
        logic [SW-1:0] s_a, s_b;
        logic [SW:0]   s_sum, es;
        logic          eo;
        logic [SW:0]   q_sum [$];
        logic          q_ovf [$];
        logic [65:0]   r;
        int unsigned   n_acc = 0;
        int unsigned   n_pop = 0;

        pipelined_doubling_adder #(.WIDTH(SW), .LVL_PER(SL)) u_dut (
            .clk(clk), .rst(s_rst), .in_valid(s_iv), .in_ready(s_ir), .a(s_a), .b(s_b),
            .cin(s_cin), .op_sub(s_sub), .out_valid(s_ov), .out_ready(s_or),
            .sum(s_sum), .ovf(s_ovf)
        );

        assign sweep_done[gi] = (n_pop >= NBEATS);

        function automatic logic [SW-1:0] rnd_op();
            case ($urandom_range(0, 7))
                0:       return '1;
                1:       return '0;
                2:       return SW'(1) << (SW - 1);
                3:       return ~(SW'(1) << (SW - 1));
                default: return SW'({$urandom, $urandom});
            endcase
        endfunction

        initial begin
            s_rst = 1'b1; s_iv = 1'b0; s_a = '0; s_b = '0; s_cin = 1'b0; s_sub = 1'b0;
            repeat (3) @(negedge clk);
            s_rst = 1'b0;
            while (n_acc < NBEATS) begin
                @(negedge clk);
                s_iv  = ($urandom_range(0, 3) != 0);
                s_a   = rnd_op();
                s_b   = rnd_op();
                s_cin = 1'($urandom);
                s_sub = 1'($urandom);
                #1;
                if (s_iv && s_ir) begin
                    r = ref_model(SW, 64'(s_a), 64'(s_b), s_cin, s_sub);
                    q_sum.push_back({r[64], r[SW-1:0]});
                    q_ovf.push_back(r[65]);
                    n_acc++;
                end
            end
            @(posedge clk);
            #1;
            s_iv = 1'b0;
        end

        always @(negedge clk) begin
            s_or = ($urandom_range(0, 2) != 0);
            #2;
            if (!s_rst && s_ov && s_or) begin
                checks++;
                n_pop++;
                if (q_sum.size() == 0) begin
                    failures++;
                    $display("FAIL sweep_w%0d_l%0d unexpected_out: sum=%h", SW, SL, s_sum);
                end else begin
                    es = q_sum.pop_front();
                    eo = q_ovf.pop_front();
                    if (s_sum !== es || s_ovf !== eo) begin
                        failures++;
                        $display("FAIL sweep_w%0d_l%0d: sum=%h ovf=%0b expected sum=%h ovf=%0b",
                                 SW, SL, s_sum, s_ovf, es, eo);
                    end
                end
            end
        end
    end

    // ---------------- directed sequence ----------------
    logic [15:0] bp_a [8];
    logic [15:0] bp_b [8];
    logic        bp_ci [8];
    logic        bp_sub [8];
    logic [16:0] bp_s [8];
    logic        bp_o [8];

    initial begin
        int          k, n, base;
        logic [65:0] r;
        rst = 1'b1; in_valid = 1'b1; a = 16'hA5A5; b = 16'h1234; cin = 1'b0; op_sub = 1'b0;
        out_ready = 1'b1; chk_lat = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_sum", 64'(sum), 64'd0);
        chk("reset_ovf", 64'(ovf), 64'd0);
        repeat (8) @(negedge clk);

        // Directed adds, carry chain and subtracts, back to back with full throughput.
        chk_lat = 1'b1;
        for (int i = 0; i < 8; i++) issue(D_A[i], D_B[i], D_CI[i], D_SUB[i], D_SUM[i], D_OVF[i]);
        drain("directed_drain");

        // Backpressure: pipe fills with exactly NREG beats, then releases all in order.
        chk_lat = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bp_a[i] = 16'($urandom); bp_b[i] = 16'($urandom);
            bp_ci[i] = 1'($urandom); bp_sub[i] = 1'($urandom);
            r = ref_model(16, 64'(bp_a[i]), 64'(bp_b[i]), bp_ci[i], bp_sub[i]);
            bp_s[i] = {r[64], r[15:0]};
            bp_o[i] = r[65];
        end
        base = n_out;
        k = 0;
        @(negedge clk);
        out_ready = 1'b0;
        for (int c = 0; c < 12; c++) begin
            if (c != 0) @(negedge clk);
            in_valid = 1'b1; a = bp_a[k]; b = bp_b[k]; cin = bp_ci[k]; op_sub = bp_sub[k];
            #1;
            if (in_ready) begin
                exp_q.push_back(exp_t'{s: bp_s[k], o: bp_o[k], c: 32'(cyc)});
                k++;
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
        chk("bp_accepts", 64'(k), 64'(NREG));
        @(negedge clk);
        #1;
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        chk("bp_out_valid_held", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        for (int i = k; i < 8; i++) issue(bp_a[i], bp_b[i], bp_ci[i], bp_sub[i], bp_s[i], bp_o[i]);
        drain("bp_drain");
        chk("bp_count", 64'(n_out - base), 64'd8);

        // Reset with three beats in flight discards them all.
        chk_lat = 1'b1;
        for (int i = 0; i < 3; i++) issue_rand();
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        base = n_out;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_sum", 64'(sum), 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        repeat (10) @(negedge clk);
        chk("midrst_no_stale", 64'(n_out - base), 64'd0);
        for (int i = 0; i < 2; i++) issue_rand();
        drain("post_rst_drain");
        chk("post_rst_count", 64'(n_out - base), 64'd2);

        n = 0;
        while (sweep_done != {NCFG{1'b1}} && n < 20000) begin
            @(negedge clk);
            n++;
        end
        chk("sweep_done", 64'(sweep_done), 64'({NCFG{1'b1}}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
